// File: rtl/irq_ctrl_unit.sv
// Fixed-priority interrupt controller: sync/latch sources, mask, edge/level mode, one IRQ to CP0 at a time.
// src_irq to HWInt is 3 edges + 1 (sync, pend, arbitrate); no backpressure, bus writes always accepted.
module irq_ctrl_unit #(
  parameter int          NSRC      = 6,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F40
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src_irq,
  input  logic            req_taken,
  input  logic            eret,
  input  logic [31:0]     bus_addr,
  input  logic            bus_we,
  input  logic [31:0]     bus_wdata,
  output logic [31:0]     bus_rdata,
  output logic            hit,
  output logic [5:0]      HWInt,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_t;

  state_t          state;
  logic [NSRC-1:0] sync1, sync2, hist;
  logic [NSRC-1:0] pend, mask, mode;
  logic [NSRC-1:0] rise, req;
  logic [2:0]      cur_id, win_id;
  logic            cur_valid, any_req;
  logic [5:0]      cur_oh, req6, hwint_q;
  logic            wr, wr_pend, wr_mask, wr_mode, take;
  logic            unused_bits;

  assign hit         = (bus_addr[31:4] == BASE_ADDR[31:4]);
  assign wr          = hit && bus_we;
  assign wr_pend     = wr && (bus_addr[3:2] == 2'd0);
  assign wr_mask     = wr && (bus_addr[3:2] == 2'd1);
  assign wr_mode     = wr && (bus_addr[3:2] == 2'd2);
  assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:NSRC]};

  assign rise   = sync2 & ~hist;
  assign req    = pend & mask;
  assign req6   = 6'(req);
  assign cur_oh = 6'b000001 << cur_id;
  assign take   = (state == ASSERT) && req_taken;
  assign HWInt  = hwint_q;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      hist  <= '0;
    end else begin
      sync1 <= src_irq;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  // Edge sources: a new rising edge beats a same-cycle W1C or acknowledge.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (mode[i]) begin
          if (rise[i])
            pend[i] <= 1'b1;
          else if ((wr_pend && bus_wdata[i]) || (take && cur_oh[i]))
            pend[i] <= 1'b0;
        end else begin
          pend[i] <= sync2[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask <= '0;
      mode <= '0;
    end else begin
      if (wr_mask) mask <= bus_wdata[NSRC-1:0];
      if (wr_mode) mode <= bus_wdata[NSRC-1:0];
    end
  end

  always_comb begin
    win_id  = 3'd0;
    any_req = 1'b0;
    for (int i = NSRC-1; i >= 0; i--) begin
      if (req[i]) begin
        win_id  = 3'(i);
        any_req = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cur_id    <= 3'd0;
      cur_valid <= 1'b0;
      hwint_q   <= 6'd0;
    end else begin
      case (state)
        IDLE: begin
          hwint_q <= 6'd0;
          if (any_req) begin
            cur_id  <= win_id;
            hwint_q <= 6'b000001 << win_id;
            state   <= ASSERT;
          end
        end
        ASSERT: begin
          if (req_taken) begin
            cur_valid <= 1'b1;
            hwint_q   <= 6'd0;
            state     <= SERVICE;
          end else if ((req6 & cur_oh) == 6'd0) begin
            hwint_q <= 6'd0;
            state   <= IDLE;
          end
        end
        SERVICE: begin
          hwint_q <= 6'd0;
          if (eret) begin
            cur_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          hwint_q <= 6'd0;
          state   <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bus_rdata = 32'd0;
    if (hit) begin
      case (bus_addr[3:2])
        2'd0:    bus_rdata = 32'(pend);
        2'd1:    bus_rdata = 32'(mask);
        2'd2:    bus_rdata = 32'(mode);
        default: bus_rdata = {27'd0, cur_valid, 1'b0, cur_id};
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl_unit.sv
// Directed bench for irq_ctrl_unit: hand-computed register/HWInt values at fixed edges.
module tb_irq_ctrl_unit;
  localparam logic [31:0] A_PEND = 32'h0000_7F40;
  localparam logic [31:0] A_MASK = 32'h0000_7F44;
  localparam logic [31:0] A_MODE = 32'h0000_7F48;
  localparam logic [31:0] A_CUR  = 32'h0000_7F4C;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  src_irq;
  logic        req_taken, eret, bus_we, hit, busy;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [5:0]  HWInt;
  int          tests = 0;
  int          failed = 0;

  irq_ctrl_unit dut (
    .clk(clk), .reset(reset), .src_irq(src_irq), .req_taken(req_taken), .eret(eret),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .hit(hit), .HWInt(HWInt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick(int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(string tag, logic [31:0] a, logic [31:0] exp);
    bus_addr = a;
    #1;
    chk(tag, bus_rdata, exp);
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d);
    bus_addr  = a;
    bus_wdata = d;
    bus_we    = 1'b1;
    tick();
    bus_we    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; src_irq = '0; req_taken = 0; eret = 0;
    bus_addr = '0; bus_we = 0; bus_wdata = '0;
    tick(2);
    reset = 1'b0;
    tick();
    chk("rst_hwint", 32'(HWInt), 0);
    chk("rst_busy", 32'(busy), 0);
    rd("rst_pend", A_PEND, 0);
    rd("rst_mask", A_MASK, 0);
    rd("rst_mode", A_MODE, 0);
    rd("rst_cur", A_CUR, 0);

    // 1: edge pulse on src 0
    wr(A_MASK, 32'h3F);
    wr(A_MODE, 32'h01);
    src_irq[0] = 1'b1; tick(); src_irq[0] = 1'b0;
    tick();
    rd("t1_pend_n1", A_PEND, 0);
    tick();
    rd("t1_pend_n2", A_PEND, 32'h01);
    chk("t1_hwint_n2", 32'(HWInt), 0);
    tick();
    chk("t1_hwint_n3", 32'(HWInt), 32'h01);
    chk("t1_busy", 32'(busy), 1);
    rd("t1_cur_assert", A_CUR, 32'h00);
    req_taken = 1; tick(); req_taken = 0;
    chk("t1_hwint_svc", 32'(HWInt), 0);
    rd("t1_cur_svc", A_CUR, 32'h10);
    rd("t1_pend_svc", A_PEND, 0);
    eret = 1; tick(); eret = 0;
    chk("t1_busy_done", 32'(busy), 0);
    rd("t1_cur_done", A_CUR, 0);

    // 2: level sources 2 and 4 together
    wr(A_MODE, 32'h00);
    src_irq[2] = 1; src_irq[4] = 1;
    tick(3);
    rd("t2_pend", A_PEND, 32'h14);
    tick();
    chk("t2_hwint_first", 32'(HWInt), 32'h04);
    req_taken = 1; tick(); req_taken = 0;
    rd("t2_cur", A_CUR, 32'h12);
    src_irq[2] = 0;
    tick(3);
    rd("t2_pend_after", A_PEND, 32'h10);
    chk("t2_hwint_svc", 32'(HWInt), 0);
    eret = 1; tick(); eret = 0;
    tick();
    chk("t2_hwint_second", 32'(HWInt), 32'h10);
    src_irq[4] = 0;
    tick(5);
    chk("t2_hwint_retract", 32'(HWInt), 0);
    chk("t2_busy_retract", 32'(busy), 0);

    // 3: mask write retracts an offered interrupt
    src_irq[1] = 1;
    tick(4);
    chk("t3_hwint", 32'(HWInt), 32'h02);
    wr(A_MASK, 32'h00);
    tick();
    chk("t3_hwint_masked", 32'(HWInt), 0);
    chk("t3_busy_masked", 32'(busy), 0);
    rd("t3_pend_kept", A_PEND, 32'h02);
    wr(A_MASK, 32'h3F);
    tick();
    chk("t3_hwint_reen", 32'(HWInt), 32'h02);
    src_irq[1] = 0;
    tick(5);
    chk("t3_hwint_clear", 32'(HWInt), 0);

    // 4: edge arrival during SERVICE waits for eret
    wr(A_MODE, 32'h09);
    src_irq[0] = 1; tick(); src_irq[0] = 0;
    tick(3);
    chk("t4_hwint_src0", 32'(HWInt), 32'h01);
    req_taken = 1; tick(); req_taken = 0;
    chk("t4_hwint_svc", 32'(HWInt), 0);
    src_irq[3] = 1; tick(); src_irq[3] = 0;
    tick(3);
    chk("t4_hwint_nonest", 32'(HWInt), 0);
    chk("t4_busy", 32'(busy), 1);
    rd("t4_pend", A_PEND, 32'h08);
    req_taken = 1; tick(); req_taken = 0;
    rd("t4_cur_ignore_take", A_CUR, 32'h10);
    rd("t4_pend_ignore_take", A_PEND, 32'h08);
    eret = 1; tick(); eret = 0;
    chk("t4_hwint_eret", 32'(HWInt), 0);
    tick();
    chk("t4_hwint_src3", 32'(HWInt), 32'h08);
    rd("t4_cur_src3", A_CUR, 32'h03);
    req_taken = 1; tick(); req_taken = 0;
    rd("t4_pend_acked", A_PEND, 0);
    rd("t4_cur_svc3", A_CUR, 32'h13);
    eret = 1; tick(); eret = 0;
    chk("t4_busy_done", 32'(busy), 0);

    // 5: set beats W1C on the same edge; address decode
    wr(A_MASK, 32'h00);
    src_irq[3] = 1;
    tick(3);
    rd("t5_pend_first", A_PEND, 32'h08);
    src_irq[3] = 0;
    tick(3);
    src_irq[3] = 1;
    tick(2);
    wr(A_PEND, 32'h08);
    rd("t5_pend_setwins", A_PEND, 32'h08);
    rd("t5_unhit", 32'h0000_7F50, 0);
    bus_addr = 32'h0000_7F50; #1;
    chk("t5_hit_low", 32'(hit), 0);
    rd("t5_lowbits_ignored", 32'h0000_7F43, 32'h08);
    chk("t5_hit_high", 32'(hit), 1);
    wr(A_PEND, 32'h08);
    rd("t5_pend_w1c", A_PEND, 0);
    wr(A_MASK, 32'hFFFF_FFFF);
    rd("t5_mask_width", A_MASK, 32'h3F);
    wr(A_MASK, 32'h00);
    src_irq[3] = 0;
    tick(3);

    // 6: reset in ASSERT, then in SERVICE
    wr(A_MODE, 32'h00);
    wr(A_MASK, 32'h3F);
    src_irq[1] = 1;
    tick(4);
    chk("t6_hwint_assert", 32'(HWInt), 32'h02);
    reset = 1; req_taken = 1; tick();
    chk("t6a_hwint", 32'(HWInt), 0);
    chk("t6a_busy", 32'(busy), 0);
    rd("t6a_pend", A_PEND, 0);
    rd("t6a_mask", A_MASK, 0);
    rd("t6a_mode", A_MODE, 0);
    rd("t6a_cur", A_CUR, 0);
    reset = 0; req_taken = 0; src_irq = '0;
    tick();
    wr(A_MASK, 32'h3F);
    src_irq[2] = 1;
    tick(4);
    chk("t6_hwint_src2", 32'(HWInt), 32'h04);
    req_taken = 1; tick(); req_taken = 0;
    chk("t6_busy_svc", 32'(busy), 1);
    reset = 1; eret = 1; tick();
    chk("t6b_hwint", 32'(HWInt), 0);
    chk("t6b_busy", 32'(busy), 0);
    rd("t6b_cur", A_CUR, 0);
    rd("t6b_mask", A_MASK, 0);
    rd("t6b_pend", A_PEND, 0);
    reset = 0; eret = 0; src_irq = '0;
    tick(2);
    chk("t6b_busy_after", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
